// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, default
// source count and the fixed-priority encoder used by the selector.
package irq_pkg;

  localparam int DEFAULT_N_SRC = 4;
  // Upper bound on sources; the encoder always works on this width.
  localparam int MAX_SRC = 8;
  localparam int MAX_ID_W = 3;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_REQ     = 2'b01;
  localparam logic [1:0] ST_SERVICE = 2'b10;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } pick_t;

  // Lowest set index wins; scanning downward lets the last hit be the lowest.
  function automatic pick_t prio_pick(input logic [MAX_SRC-1:0] req);
    pick_t p;
    p.valid = 1'b0;
    p.id    = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        p.valid = 1'b1;
        p.id    = MAX_ID_W'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source input conditioning: two-flop synchronizer followed by a history
// flop, producing a single-cycle rise strobe in the clk domain.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic sync1_reg;
  logic sync2_reg;
  logic hist_reg;

  // History clears on reset, so a line already high at release counts as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      hist_reg  <= 1'b0;
    end else begin
      sync1_reg <= async_in;
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;
    end
  end

  assign rise = sync2_reg & ~hist_reg;

endmodule

// File: rtl/irq_controller.sv
// Requester side of the core's single interrupt line: latches edge requests
// as pending, picks the highest-priority unmasked one and runs a
// request / service / end-of-interrupt handshake without nesting.
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_SRC = DEFAULT_N_SRC,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] irq_mask,
  output logic             int_out,
  output logic [ID_W-1:0]  int_id,
  input  logic             int_ack,
  input  logic             eoi,
  output logic [N_SRC-1:0] pending,
  output logic             busy,
  output logic             spurious_eoi
);

  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   eligible;
  logic [MAX_SRC-1:0] eligible_ext;
  pick_t              pick;

  logic [N_SRC-1:0] pending_reg, pending_next;
  logic [1:0]       state_reg, state_next;
  logic [ID_W-1:0]  int_id_reg, int_id_next;
  logic             int_out_reg, int_out_next;
  logic             busy_reg, busy_next;
  logic             spurious_reg, spurious_next;
  logic             ack_clr;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      irq_sync_edge u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .async_in (irq_in[gi]),
        .rise     (rise[gi])
      );

      assign eligible[gi] = pending_reg[gi] & ~irq_mask[gi];

      // A fresh rise in the ack cycle keeps the bit set so it is serviced again.
      assign pending_next[gi] = rise[gi] |
                                (pending_reg[gi] & ~(ack_clr && (int_id_reg == ID_W'(gi))));
    end
  endgenerate

  assign eligible_ext = MAX_SRC'(eligible);
  assign pick         = prio_pick(eligible_ext);

  always_comb begin
    state_next  = state_reg;
    int_id_next = int_id_reg;
    ack_clr     = 1'b0;
    case (state_reg)
      ST_REQ: begin
        if (int_ack) begin
          ack_clr    = 1'b1;
          state_next = ST_SERVICE;
        end else if (!pending_reg[int_id_reg] || irq_mask[int_id_reg]) begin
          state_next = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        // Covers IDLE and the unused 2'b11 encoding.
        if (pick.valid) begin
          state_next  = ST_REQ;
          int_id_next = ID_W'(pick.id);
        end
      end
    endcase
  end

  assign int_out_next  = (state_next == ST_REQ);
  assign busy_next     = (state_next == ST_REQ) || (state_next == ST_SERVICE);
  assign spurious_next = spurious_reg | (eoi && (state_reg != ST_SERVICE));

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg  <= '0;
      state_reg    <= ST_IDLE;
      int_id_reg   <= '0;
      int_out_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      spurious_reg <= 1'b0;
    end else begin
      pending_reg  <= pending_next;
      state_reg    <= state_next;
      int_id_reg   <= int_id_next;
      int_out_reg  <= int_out_next;
      busy_reg     <= busy_next;
      spurious_reg <= spurious_next;
    end
  end

  assign int_out      = int_out_reg;
  assign int_id       = int_id_reg;
  assign pending      = pending_reg;
  assign busy         = busy_reg;
  assign spurious_eoi = spurious_reg;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: hand-computed expectations, one line per
// transaction, single summary line at the end.
module tb_irq_controller;

  logic       clk;
  logic       rst;
  logic [3:0] irq_in;
  logic [3:0] irq_mask;
  logic       int_out;
  logic [1:0] int_id;
  logic       int_ack;
  logic       eoi;
  logic [3:0] pending;
  logic       busy;
  logic       spurious_eoi;

  int err_cnt = 0;
  int chk_cnt = 0;

  irq_controller #(.N_SRC(4), .ID_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_in       (irq_in),
    .irq_mask     (irq_mask),
    .int_out      (int_out),
    .int_id       (int_id),
    .int_ack      (int_ack),
    .eoi          (eoi),
    .pending      (pending),
    .busy         (busy),
    .spurious_eoi (spurious_eoi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = 4'b0000; irq_mask = 4'b0000; int_ack = 1'b0; eoi = 1'b0;
    tick(2);
    rst = 1'b0;
    $display("reset: int_out=%0b pending=%b busy=%0b int_id=%0d spurious=%0b",
             int_out, pending, busy, int_id, spurious_eoi);
    check("rst_int_out", 32'(int_out), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_int_id", 32'(int_id), 32'd0);
    check("rst_spurious", 32'(spurious_eoi), 32'd0);
    tick(2);

    // Single request on source 2: exact 4-edge latency.
    irq_in = 4'b0100;
    tick(2);
    check("single_pend_e2", 32'(pending), 32'b0000);
    tick();
    check("single_pend_e3", 32'(pending), 32'b0100);
    check("single_int_e3", 32'(int_out), 32'd0);
    tick();
    $display("single: E4 int_out=%0b int_id=%0d busy=%0b", int_out, int_id, busy);
    check("single_int_e4", 32'(int_out), 32'd1);
    check("single_id_e4", 32'(int_id), 32'd2);
    check("single_busy_e4", 32'(busy), 32'd1);
    irq_in = 4'b0000;
    tick();
    check("single_hold_e5", 32'(int_out), 32'd1);
    pulse_ack();
    $display("single: ack int_out=%0b pending=%b busy=%0b", int_out, pending, busy);
    check("single_ack_int", 32'(int_out), 32'd0);
    check("single_ack_pend", 32'(pending), 32'b0000);
    check("single_ack_busy", 32'(busy), 32'd1);
    pulse_ack();
    check("svc_ack_ignored", 32'({busy, int_out}), 32'b10);
    tick();
    pulse_eoi();
    $display("single: eoi busy=%0b spurious=%0b", busy, spurious_eoi);
    check("single_eoi_busy", 32'(busy), 32'd0);
    check("single_eoi_spur", 32'(spurious_eoi), 32'd0);
    tick(2);

    // Priority between sources 3 and 1 arriving together.
    irq_in = 4'b1010;
    tick(4);
    $display("prio: first int_id=%0d pending=%b", int_id, pending);
    check("prio_first_int", 32'(int_out), 32'd1);
    check("prio_first_id", 32'(int_id), 32'd1);
    check("prio_first_pend", 32'(pending), 32'b1010);
    irq_in = 4'b0000;
    pulse_ack();
    check("prio_ack_pend", 32'(pending), 32'b1000);
    pulse_eoi();
    check("prio_idle_int", 32'(int_out), 32'd0);
    tick();
    $display("prio: second int_id=%0d int_out=%0b", int_id, int_out);
    check("prio_second_int", 32'(int_out), 32'd1);
    check("prio_second_id", 32'(int_id), 32'd3);
    pulse_ack();
    pulse_eoi();
    check("prio_done_pend", 32'(pending), 32'b0000);
    tick(2);

    // Mask while requesting withdraws; unmask reasserts.
    irq_in = 4'b0001;
    tick(4);
    check("mask_req_id", 32'(int_id), 32'd0);
    check("mask_req_int", 32'(int_out), 32'd1);
    irq_mask = 4'b0001;
    tick();
    $display("mask: withdraw int_out=%0b busy=%0b pending=%b", int_out, busy, pending);
    check("mask_wd_int", 32'(int_out), 32'd0);
    check("mask_wd_busy", 32'(busy), 32'd0);
    check("mask_wd_pend", 32'(pending), 32'b0001);
    tick();
    check("mask_stay_idle", 32'(int_out), 32'd0);
    irq_mask = 4'b0000;
    tick();
    $display("mask: unmask int_out=%0b int_id=%0d", int_out, int_id);
    check("mask_re_int", 32'(int_out), 32'd1);
    check("mask_re_id", 32'(int_id), 32'd0);
    irq_in = 4'b0000;
    pulse_ack();
    pulse_eoi();
    tick(3);

    // Fresh rise on source 2 coinciding with its ack: set wins.
    irq_in = 4'b0100;
    tick(4);
    check("collide_req_id", 32'(int_id), 32'd2);
    irq_in = 4'b0000;
    tick(3);
    check("collide_still_req", 32'(int_out), 32'd1);
    irq_in = 4'b0100;
    tick(2);
    pulse_ack();
    $display("collide: ack pending=%b int_out=%0b busy=%0b", pending, int_out, busy);
    check("collide_pend", 32'(pending), 32'b0100);
    check("collide_svc", 32'({busy, int_out}), 32'b10);
    pulse_eoi();
    tick();
    $display("collide: rerequest int_out=%0b int_id=%0d", int_out, int_id);
    check("collide_re_int", 32'(int_out), 32'd1);
    check("collide_re_id", 32'(int_id), 32'd2);
    irq_in = 4'b0000;
    pulse_ack();
    pulse_eoi();
    tick(3);

    // eoi in IDLE is spurious and sticky.
    check("spur_pre", 32'(spurious_eoi), 32'd0);
    pulse_eoi();
    $display("spurious: spurious_eoi=%0b busy=%0b", spurious_eoi, busy);
    check("spur_set", 32'(spurious_eoi), 32'd1);
    tick(3);
    check("spur_sticky", 32'(spurious_eoi), 32'd1);

    // Reset during REQ aborts; line still high is seen as a new edge.
    irq_in = 4'b0010;
    tick(4);
    check("rreq_int", 32'(int_out), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset_req: int_out=%0b busy=%0b pending=%b spurious=%0b",
             int_out, busy, pending, spurious_eoi);
    check("rreq_int_after", 32'(int_out), 32'd0);
    check("rreq_busy_after", 32'(busy), 32'd0);
    check("rreq_pend_after", 32'(pending), 32'b0000);
    check("rreq_spur_after", 32'(spurious_eoi), 32'd0);
    tick(2);
    check("rel_pend_e2", 32'(pending), 32'b0000);
    tick();
    check("rel_pend_e3", 32'(pending), 32'b0010);
    tick();
    $display("reset_release: int_out=%0b int_id=%0d", int_out, int_id);
    check("rel_int_e4", 32'(int_out), 32'd1);
    check("rel_id_e4", 32'(int_id), 32'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Requester end of the core's single `int` line: the core is the responder that takes `int` and later executes RTI.
- Collects N external interrupt sources and synchronizes each one.
- Edge-detects and latches each source as pending, then picks the highest-priority unmasked source.
- Drives the core's `int` input until the core acknowledges ISR entry, then blocks further requests until the core signals RTI retirement (end-of-interrupt). No nesting.

Parameters:
- N_SRC, 4, number of interrupt sources (2..8).
- ID_W, 2, width of the source id; must equal ceil(log2(N_SRC)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  N_SRC  raw source lines, asynchronous; a rising edge is a request.
- irq_mask  in  N_SRC  1 = source masked; it still latches pending but is not selected.
- int_out  out  1  level request to the core's `int`.
- int_id  out  ID_W  id of the source being requested or serviced.
- int_ack  in  1  one-cycle pulse: core has vectored to the ISR.
- eoi  in  1  one-cycle pulse: core retired RTI.
- pending  out  N_SRC  latched pending bits.
- busy  out  1  high in REQ or SERVICE.
- spurious_eoi  out  1  sticky: eoi received outside SERVICE.

Behaviour:
- Reset: one clk edge with rst=1 clears synchronizers, edge history, pending, int_out, int_id, busy and spurious_eoi, and sets state to IDLE.
  - Reset mid-REQ or mid-SERVICE aborts without any handshake.
  - Edge history resets to 0, so a source that is high at reset release counts as a rising edge.
- Input path per source:
  - 2-flop synchronizer, then a history flop.
  - rise = sync2 & ~hist.
  - pending[i] sets on rise.
- Latency: irq_in goes high before edge E1. sync1 loads at E1, sync2 at E2, pending at E3, int_out=1 after E4. Minimum 4 edges, exactly.
- Selection: sel = lowest index i with pending[i] & ~irq_mask[i]; index 0 is highest priority.
- FSM states, registered outputs:
  - IDLE (int_out=0, busy=0): if any eligible source exists, latch int_id=sel and go to REQ.
  - REQ (int_out=1, busy=1): int_id is frozen.
    - If int_ack: clear pending[int_id] and go to SERVICE.
    - Else if pending[int_id]=0 or irq_mask[int_id]=1: withdraw and go to IDLE. A higher-priority source arriving does not preempt REQ.
  - SERVICE (int_out=0, busy=1): int_id is held.
    - On eoi go to IDLE.
    - The next request may assert int_out no earlier than 1 cycle after IDLE is entered, because IDLE→REQ costs 1 edge.
- Simultaneous events:
  - A rise on source int_id in the same cycle as int_ack: set wins, pending stays 1 and is serviced later.
  - int_ack and a withdraw condition in the same cycle: ack wins.
  - int_ack outside REQ is ignored.
  - eoi outside SERVICE is ignored and sets spurious_eoi.
- Repeated edges on an already-pending source merge into one request; there is no counting.
- Sources masked while pending keep their pending bit and become eligible when unmasked.

Decomposition:
- Shared package `irq_pkg`:
  - state encoding: IDLE=2'b00, REQ=2'b01, SERVICE=2'b10; 2'b11 is illegal and decodes to IDLE.
  - default N_SRC.
  - the priority-encode function.
- Sub-module irq_sync_edge: one instance per source, holding the 2-flop sync plus history flop, with output rise.
- The top holds pending, the selector and the FSM.

Test Plan:
- Reset: hold rst=1 for 2 edges with irq_in=4'b0000 → int_out=0, pending=0, busy=0, int_id=0, spurious_eoi=0.
- Single request: pulse irq_in[2] high before E1 → pending=4'b0100 after E3, int_out=1 and int_id=2 after E4; int_ack at E6 → int_out=0, pending=0, state SERVICE; eoi at E9 → busy=0.
- Priority: raise irq_in[3] and irq_in[1] in the same cycle → int_id=1 first; after ack and eoi → int_id=3.
- Mask and withdraw: irq_in[0] rises, then irq_mask[0]=1 while in REQ before any ack → int_out drops next edge, pending[0] stays 1; clear the mask → request reasserts with int_id=0.
- Set-wins collision: irq_in[2] has a fresh rise in the same cycle as int_ack for id 2 → after eoi, a second request with int_id=2 appears.
- Spurious and reset: eoi while IDLE → spurious_eoi=1 and stays 1; rst asserted during REQ → next edge int_out=0, state IDLE, pending=0.
